mux_pack_n: RTL and testbench

MUX_PACK_N -- requirements
Module: mux_pack_n

---
 rtl/mux_pack_n.sv | 94 +++++++++
 tb/tb_mux_pack_n.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mux_pack_n.sv
// mux_pack_n: packs RATIO narrow input beats into one wide output word.
// Beats fill lanes 0..RATIO-1. A full word, or a flushed partial word, is
// loaded into a one-deep output register with valid/ready handshaking.
// Unfilled lanes of a partial word carry PAD_VAL, and lanes_out reports
// how many lanes hold real data.
module mux_pack_n #(
    parameter int              IN_W      = 8,
    parameter int              RATIO     = 4,
    parameter int              MSB_FIRST = 1,
    parameter logic [IN_W-1:0] PAD_VAL   = '0
) (
    input  logic                         clk_4f,
    input  logic                         reset,
    input  logic [IN_W-1:0]              data_in,
    input  logic                         valid_in,
    input  logic                         flush_in,
    output logic                         ready_in,
    output logic [IN_W*RATIO-1:0]        data_out,
    output logic                         valid_out,
    input  logic                         ready_out,
    output logic [$clog2(RATIO+1)-1:0]   lanes_out,
    output logic                         busy
);

    localparam int CW = $clog2(RATIO);
    localparam int LW = $clog2(RATIO + 1);

    logic [CW-1:0]                 cnt_reg;
    logic [RATIO-1:0][IN_W-1:0]    acc_reg;
    logic [RATIO-1:0][IN_W-1:0]    lane_val;
    logic [IN_W*RATIO-1:0]         word_next;
    logic [LW-1:0]                 lanes_next;
    logic                          accept;
    logic                          last_beat;
    logic                          do_flush;
    logic                          emit;

    // The output register can take a new word whenever it is empty or being drained.
    assign ready_in   = !valid_out || ready_out;
    assign accept     = valid_in && ready_in;
    assign last_beat  = accept && (cnt_reg == CW'(RATIO - 1));
    // A flush with nothing held and no beat arriving is a no-op.
    assign do_flush   = flush_in && ready_in && (accept || (cnt_reg != '0));
    assign emit       = last_beat || do_flush;
    // The beat arriving this cycle (if any) counts as a real lane.
    assign lanes_next = LW'(cnt_reg) + LW'(accept);
    assign busy       = (cnt_reg != '0);

    // Build the outgoing word: held lanes, then the arriving beat, then padding.
    generate
        for (genvar gi = 0; gi < RATIO; gi++) begin : g_lane
            assign lane_val[gi] = (CW'(gi) < cnt_reg)                  ? acc_reg[gi] :
                                  (accept && (cnt_reg == CW'(gi)))     ? data_in     :
                                                                         PAD_VAL;
            if (MSB_FIRST != 0) begin : g_msb
                assign word_next[(RATIO-1-gi)*IN_W +: IN_W] = lane_val[gi];
            end else begin : g_lsb
                assign word_next[gi*IN_W +: IN_W] = lane_val[gi];
            end
        end
    endgenerate

    // Accumulator: store each accepted beat in the lane selected by the counter.
    always_ff @(posedge clk_4f or posedge reset) begin
        if (reset) begin
            acc_reg <= '0;
        end else if (accept) begin
            acc_reg[cnt_reg] <= data_in;
        end
    end

    // Lane counter and output word register with handshake.
    always_ff @(posedge clk_4f or posedge reset) begin
        if (reset) begin
            cnt_reg   <= '0;
            data_out  <= '0;
            lanes_out <= '0;
            valid_out <= 1'b0;
        end else if (emit) begin
            cnt_reg   <= '0;
            data_out  <= word_next;
            lanes_out <= lanes_next;
            valid_out <= 1'b1;
        end else begin
            if (ready_out) begin
                valid_out <= 1'b0;
            end
            if (accept) begin
                cnt_reg <= cnt_reg + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mux_pack_n.sv
// Testbench for mux_pack_n: directed vector table, hand-written corner
// sequences and a randomized run against a queue-based reference model.
module tb_mux_pack_n;

    logic        clk_4f = 1'b0;
    logic        reset;
    logic [7:0]  data_in;
    logic        valid_in;
    logic        flush_in;
    logic        ready_out;

    // Default instance (MSB first, zero padding)
    logic        ready_in;
    logic [31:0] data_out;
    logic        valid_out;
    logic [2:0]  lanes_out;
    logic        busy;

    // LSB-first instance with non-zero padding, same inputs
    logic        ready_in1;
    logic [31:0] data_out1;
    logic        valid_out1;
    logic [2:0]  lanes_out1;
    logic        busy1;

    // Narrow-beat instance IN_W=4, RATIO=8
    logic [3:0]  data_in2;
    logic        valid_in2;
    logic        ready_in2;
    logic [31:0] data_out2;
    logic        valid_out2;
    logic [3:0]  lanes_out2;
    logic        busy2;

    int checks   = 0;
    int failures = 0;

    always #5 clk_4f = ~clk_4f;

    mux_pack_n u0 (
        .clk_4f(clk_4f), .reset(reset), .data_in(data_in), .valid_in(valid_in),
        .flush_in(flush_in), .ready_in(ready_in), .data_out(data_out),
        .valid_out(valid_out), .ready_out(ready_out), .lanes_out(lanes_out), .busy(busy)
    );

    mux_pack_n #(.MSB_FIRST(0), .PAD_VAL(8'h5A)) u1 (
        .clk_4f(clk_4f), .reset(reset), .data_in(data_in), .valid_in(valid_in),
        .flush_in(flush_in), .ready_in(ready_in1), .data_out(data_out1),
        .valid_out(valid_out1), .ready_out(ready_out), .lanes_out(lanes_out1), .busy(busy1)
    );

    mux_pack_n #(.IN_W(4), .RATIO(8)) u2 (
        .clk_4f(clk_4f), .reset(reset), .data_in(data_in2), .valid_in(valid_in2),
        .flush_in(1'b0), .ready_in(ready_in2), .data_out(data_out2),
        .valid_out(valid_out2), .ready_out(1'b1), .lanes_out(lanes_out2), .busy(busy2)
    );

    // Reference model: beats held so far, and the word currently presented.
    logic [7:0]  q[$];
    bit          exp_valid = 1'b0;
    logic [31:0] exp_w0    = '0;
    logic [31:0] exp_w1    = '0;
    int          exp_lanes = 0;

    function automatic logic [31:0] pack(input bit msb, input logic [7:0] pad);
        logic [31:0] w;
        logic [7:0]  b;
        int          sh;
        w = '0;
        for (int k = 0; k < 4; k++) begin
            b  = (k < q.size()) ? q[k] : pad;
            sh = msb ? (3 - k) * 8 : k * 8;
            w  = w | (32'(b) << sh);
        end
        return w;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        exp_valid = 1'b0;
        exp_w0    = '0;
        exp_w1    = '0;
        exp_lanes = 0;
    endtask

    // One clock cycle: drive inputs, check ready, advance model, check outputs.
    task automatic step(input logic v, input logic [7:0] d, input logic f, input logic ro);
        bit rdy;
        valid_in  = v;
        data_in   = d;
        flush_in  = f;
        ready_out = ro;
        #1;
        rdy = !exp_valid || ro;
        check("ready_in", 64'(ready_in), 64'(rdy));
        check("ready_in_lsb", 64'(ready_in1), 64'(rdy));
        if (valid_out && ro)
            $display("xfer data=%08h lanes=%0d", data_out, lanes_out);
        @(posedge clk_4f);
        if (v && rdy) q.push_back(d);
        if (q.size() == 4 || (f && rdy && q.size() > 0)) begin
            exp_w0    = pack(1'b1, 8'h00);
            exp_w1    = pack(1'b0, 8'h5A);
            exp_lanes = q.size();
            exp_valid = 1'b1;
            q.delete();
        end else if (ro) begin
            exp_valid = 1'b0;
        end
        #1;
        check("valid_out", 64'(valid_out), 64'(exp_valid));
        check("data_out", 64'(data_out), 64'(exp_w0));
        check("lanes_out", 64'(lanes_out), 64'(exp_lanes));
        check("busy", 64'(busy), 64'(q.size() != 0));
        check("valid_out_lsb", 64'(valid_out1), 64'(exp_valid));
        check("data_out_lsb", 64'(data_out1), 64'(exp_w1));
        check("lanes_out_lsb", 64'(lanes_out1), 64'(exp_lanes));
    endtask

    task automatic check_reset_state();
        check("rst_data_out", 64'(data_out), 64'h0);
        check("rst_valid_out", 64'(valid_out), 64'h0);
        check("rst_lanes_out", 64'(lanes_out), 64'h0);
        check("rst_busy", 64'(busy), 64'h0);
        check("rst_data_out_lsb", 64'(data_out1), 64'h0);
        check("rst_valid_out_lsb", 64'(valid_out1), 64'h0);
        check("rst_data_out_narrow", 64'(data_out2), 64'h0);
        check("rst_valid_out_narrow", 64'(valid_out2), 64'h0);
    endtask

    typedef struct {
        logic        v;
        logic [7:0]  d;
        logic        f;
        logic        ro;
        logic        ev;
        logic [31:0] e0;
        logic [31:0] e1;
        logic [2:0]  el;
    } vec_t;

    vec_t tbl[12];

    initial begin
        logic [7:0] nd;
        tbl[0]  = '{1'b1, 8'hA1, 1'b0, 1'b1, 1'b0, 32'h00000000, 32'h00000000, 3'd0};
        tbl[1]  = '{1'b1, 8'hB2, 1'b0, 1'b1, 1'b0, 32'h00000000, 32'h00000000, 3'd0};
        tbl[2]  = '{1'b1, 8'hC3, 1'b0, 1'b1, 1'b0, 32'h00000000, 32'h00000000, 3'd0};
        tbl[3]  = '{1'b1, 8'hD4, 1'b0, 1'b1, 1'b1, 32'hA1B2C3D4, 32'hD4C3B2A1, 3'd4};
        tbl[4]  = '{1'b1, 8'h11, 1'b0, 1'b1, 1'b0, 32'hA1B2C3D4, 32'hD4C3B2A1, 3'd4};
        tbl[5]  = '{1'b1, 8'h22, 1'b0, 1'b1, 1'b0, 32'hA1B2C3D4, 32'hD4C3B2A1, 3'd4};
        tbl[6]  = '{1'b0, 8'hEE, 1'b1, 1'b1, 1'b1, 32'h11220000, 32'h5A5A2211, 3'd2};
        tbl[7]  = '{1'b1, 8'h11, 1'b0, 1'b1, 1'b0, 32'h11220000, 32'h5A5A2211, 3'd2};
        tbl[8]  = '{1'b1, 8'h22, 1'b0, 1'b1, 1'b0, 32'h11220000, 32'h5A5A2211, 3'd2};
        tbl[9]  = '{1'b1, 8'h33, 1'b1, 1'b1, 1'b1, 32'h11223300, 32'h5A332211, 3'd3};
        tbl[10] = '{1'b0, 8'h99, 1'b1, 1'b1, 1'b0, 32'h11223300, 32'h5A332211, 3'd3};
        tbl[11] = '{1'b0, 8'h98, 1'b0, 1'b1, 1'b0, 32'h11223300, 32'h5A332211, 3'd3};

        reset     = 1'b1;
        data_in   = '0;
        valid_in  = 1'b0;
        flush_in  = 1'b0;
        ready_out = 1'b1;
        data_in2  = '0;
        valid_in2 = 1'b0;
        repeat (2) @(posedge clk_4f);
        #1;
        check_reset_state();
        reset = 1'b0;
        model_reset();

        // Directed vector table
        for (int i = 0; i < 12; i++) begin
            step(tbl[i].v, tbl[i].d, tbl[i].f, tbl[i].ro);
            check($sformatf("tbl%0d_valid", i), 64'(valid_out), 64'(tbl[i].ev));
            check($sformatf("tbl%0d_data", i), 64'(data_out), 64'(tbl[i].e0));
            check($sformatf("tbl%0d_data_lsb", i), 64'(data_out1), 64'(tbl[i].e1));
            check($sformatf("tbl%0d_lanes", i), 64'(lanes_out), 64'(tbl[i].el));
        end

        // Backpressure: valid_in held high, downstream stalls for a while
        nd = 8'h60;
        for (int i = 0; i < 14; i++) begin
            bit will_accept;
            will_accept = !exp_valid || (i >= 10);
            step(1'b1, nd, 1'b0, (i >= 10));
            if (will_accept) nd++;
            if (i == 9) begin
                check("stall_ready_in", 64'(ready_in), 64'h0);
                check("stall_data_hold", 64'(data_out), 64'h60616263);
                check("stall_valid_hold", 64'(valid_out), 64'h1);
            end
        end
        check("after_stall_word", 64'(data_out), 64'h64656667);
        check("after_stall_valid", 64'(valid_out), 64'h1);

        // Reset in the middle of a partial word
        step(1'b1, 8'h77, 1'b0, 1'b1);
        step(1'b1, 8'h88, 1'b0, 1'b1);
        check("pre_reset_busy", 64'(busy), 64'h1);
        reset = 1'b1;
        #1;
        check_reset_state();
        @(posedge clk_4f);
        #1;
        check_reset_state();
        reset = 1'b0;
        model_reset();
        for (int i = 1; i <= 4; i++) step(1'b1, 8'(i), 1'b0, 1'b1);
        check("post_reset_word", 64'(data_out), 64'h01020304);
        check("post_reset_lanes", 64'(lanes_out), 64'd4);

        // Narrow beats, 8 per word, continuous stream
        for (int i = 0; i < 16; i++) begin
            valid_in2 = 1'b1;
            data_in2  = 4'(i);
            step(1'b0, 8'h00, 1'b0, 1'b1);
            check($sformatf("narrow_valid_%0d", i), 64'(valid_out2), 64'((i == 7) || (i == 15)));
            if (i == 7) begin
                check("narrow_word0", 64'(data_out2), 64'h01234567);
                check("narrow_lanes0", 64'(lanes_out2), 64'd8);
            end
            if (i == 15) begin
                check("narrow_word1", 64'(data_out2), 64'h89ABCDEF);
                check("narrow_busy", 64'(busy2), 64'h0);
            end
        end
        valid_in2 = 1'b0;

        // Randomized traffic against the reference model
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 9) < 7), 8'($urandom), ($urandom_range(0, 9) == 0),
                 ($urandom_range(0, 9) < 7));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
